mem_stage: RTL and testbench

//  - RV64 MEM pipeline stage. Sits between EX and WB. Registers the EX/MEM payload and drives a req/ack data-memory port.
//  - Performs store lane steering and load alignment/sign-extension.
//  - Produces the MEM/WB register that feeds the write-back stage: ctrl_wb, mem_data, alu_data, rd_wb.
//  - Stalls upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 54 +++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and store-steering helpers for the RV64 MEM stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int unsigned CTRL_MEM_LOAD  = 1;
  localparam int unsigned CTRL_MEM_STORE = 0;
  localparam int unsigned CTRL_WB_SEL    = 1;
  localparam int unsigned CTRL_WB_WE     = 0;

  // Size is carried in funct3[1:0]; bytes past lane 7 fall off the mask.
  function automatic logic [7:0] store_strb(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] strb;
    case (f3[1:0])
      2'b00:   strb = 8'h01 << off;
      2'b01:   strb = 8'h03 << off;
      2'b10:   strb = 8'h0F << off;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

  function automatic logic [63:0] store_lanes(input logic [2:0] f3, input logic [63:0] data);
    logic [63:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {8{data[7:0]}};
      2'b01:   lanes = {4{data[15:0]}};
      2'b10:   lanes = {2{data[31:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: shifts the addressed bytes down to lane 0 and extends per funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    data = shifted;
      F3_BU:   data = {56'd0, shifted[7:0]};
      F3_HU:   data = {48'd0, shifted[15:0]};
      F3_WU:   data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: EX/MEM -> req/ack data port -> MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN adds a registered misalign flag and skips misaligned accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        ctrl_mem,
  input  logic [2:0]        funct3,
  input  logic [1:0]        ctrl_wb_in,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [4:0]        rd_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic [1:0]        ctrl_wb,
  output logic [XLEN-1:0]   mem_data,
  output logic [XLEN-1:0]   alu_data,
  output logic [4:0]        rd_wb
);

  logic [0:0]      state;
  logic            is_load;
  logic            is_store;
  logic            memop;
  logic            mis;
  logic            go_mem;

  logic [XLEN-1:0] lat_alu;
  logic [2:0]      lat_f3;
  logic [4:0]      lat_rd;
  logic [1:0]      lat_wb;
  logic            lat_load;
  logic [XLEN-1:0] ld_data;

  // Load wins when both control bits are set.
  assign is_load  = ctrl_mem[CTRL_MEM_LOAD];
  assign is_store = ctrl_mem[CTRL_MEM_STORE] & ~is_load;
  assign memop    = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = memop & misaligned(funct3, alu_result[2:0]);
`else
  assign mis = 1'b0;
`endif

  assign go_mem = in_valid & memop & ~mis;
  assign stall  = ((state == IDLE) & go_mem) | ((state == WAIT) & ~dmem_ack);

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (lat_alu[2:0]),
    .funct3 (lat_f3),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      lat_alu    <= '0;
      lat_f3     <= '0;
      lat_rd     <= '0;
      lat_wb     <= '0;
      lat_load   <= 1'b0;
      ctrl_wb    <= '0;
      mem_data   <= '0;
      alu_data   <= '0;
      rd_wb      <= '0;
    end else begin
      // Default MEM/WB contents are a bubble; only completing slots overwrite it.
      ctrl_wb  <= '0;
      mem_data <= '0;
      alu_data <= '0;
      rd_wb    <= '0;
      case (state)
        IDLE: begin
          if (go_mem) begin
            state      <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result[ADDR_W-1:3], 3'b000};
            dmem_wdata <= is_store ? store_lanes(funct3, store_data) : '0;
            dmem_wstrb <= is_store ? store_strb(funct3, alu_result[2:0]) : 8'h00;
            lat_alu    <= alu_result;
            lat_f3     <= funct3;
            lat_rd     <= rd_in;
            lat_wb     <= is_store ? {ctrl_wb_in[CTRL_WB_SEL], 1'b0} : ctrl_wb_in;
            lat_load   <= is_load;
          end else if (in_valid) begin
            // Only a trapped misaligned access reaches here with memop set.
            ctrl_wb  <= memop ? {ctrl_wb_in[CTRL_WB_SEL], 1'b0} : ctrl_wb_in;
            alu_data <= alu_result;
            rd_wb    <= rd_in;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 8'h00;
            ctrl_wb    <= lat_wb;
            mem_data   <= lat_load ? ld_data : '0;
            alu_data   <= lat_alu;
            rd_wb      <= lat_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (state == IDLE) & in_valid & mis;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a byte-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  ctrl_mem;
  logic [2:0]  funct3;
  logic [1:0]  ctrl_wb_in;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [4:0]  rd_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  ctrl_wb;
  logic [63:0] mem_data;
  logic [63:0] alu_data;
  logic [4:0]  rd_wb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .ctrl_mem   (ctrl_mem),
    .funct3     (funct3),
    .ctrl_wb_in (ctrl_wb_in),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .ctrl_wb    (ctrl_wb),
    .mem_data   (mem_data),
    .alu_data   (alu_data),
    .rd_wb      (rd_wb)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte-granular view of an access of 1/2/4/8 bytes at an offset.
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                           input logic [2:0] f3);
    logic [63:0] v = '0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) begin
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_strb(input int off, input logic [2:0] f3);
    logic [63:0] s = '0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] sd, input logic [2:0] f3);
    logic [63:0] w;
    int n = size_of(f3);
    for (int lane = 0; lane < 8; lane++) w[8*lane +: 8] = sd[8*(lane % n) +: 8];
    return w;
  endfunction

  task automatic idle_inputs();
    in_valid   = 1'b0;
    ctrl_mem   = 2'b00;
    funct3     = 3'b000;
    ctrl_wb_in = 2'b00;
    alu_result = '0;
    store_data = '0;
    rd_in      = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_op(input logic [1:0] cm, input logic [2:0] f3, input logic [1:0] wb,
                        input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                        input int dly, input logic [63:0] rdata);
    logic        memop = (cm != 2'b00);
    logic        ld    = cm[1];
    logic        st    = (cm == 2'b01);
    int          off   = int'(alu[2:0]);
    logic [63:0] exp_addr = {32'd0, alu[31:3], 3'b000};
    in_valid   = 1'b1;
    ctrl_mem   = cm;
    funct3     = f3;
    ctrl_wb_in = wb;
    alu_result = alu;
    store_data = sd;
    rd_in      = rd;
    if (!memop) begin
      @(negedge clk);
      check_eq("alu_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("alu_ctrl_wb", 64'(ctrl_wb), 64'(wb));
      check_eq("alu_data", alu_data, alu);
      check_eq("alu_rd", 64'(rd_wb), 64'(rd));
      check_eq("alu_mem_data", mem_data, 64'd0);
    end else begin
      @(negedge clk);
      check_eq("mem_stall_idle", 64'(stall), 64'd1);
      check_eq("mem_req_idle", 64'(dmem_req), 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k <= dly; k++) begin
        if (k == dly) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        @(negedge clk);
        check_eq("wait_stall", 64'(stall), (k == dly) ? 64'd0 : 64'd1);
        check_eq("wait_req", 64'(dmem_req), 64'd1);
        check_eq("wait_addr", 64'(dmem_addr), exp_addr);
        check_eq("wait_we", 64'(dmem_we), 64'(st));
        check_eq("wait_ctrl_wb", 64'(ctrl_wb), 64'd0);
        if (st) begin
          check_eq("wait_wstrb", 64'(dmem_wstrb), ref_strb(off, f3));
          check_eq("wait_wdata", dmem_wdata, ref_wdata(sd, f3));
        end
        @(posedge clk); #1;
      end
      dmem_ack   = 1'b0;
      dmem_rdata = 64'({$urandom, $urandom});
      in_valid   = 1'b0;
      @(negedge clk);
      check_eq("done_req", 64'(dmem_req), 64'd0);
      check_eq("done_ctrl_wb", 64'(ctrl_wb), st ? 64'({wb[1], 1'b0}) : 64'(wb));
      check_eq("done_mem_data", mem_data, ld ? ref_load(rdata, off, f3) : 64'd0);
      check_eq("done_alu_data", alu_data, alu);
      check_eq("done_rd", 64'(rd_wb), 64'(rd));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bubble_ctrl_wb", 64'(ctrl_wb), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_req", 64'(dmem_req), 64'd0);
    check_eq("rst_ctrl_wb", 64'(ctrl_wb), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_alu_data", alu_data, 64'd0);
    @(posedge clk); #1;

    // ALU pass-through
    run_op(2'b00, 3'b000, 2'b11, 64'h1234, 64'd0, 5'd5, 0, 64'd0);
    // lb / lbu at offset 3
    run_op(2'b10, 3'b000, 2'b01, 64'h1003, 64'd0, 5'd7, 0, 64'h0000_0000_8000_0000);
    run_op(2'b10, 3'b100, 2'b01, 64'h1003, 64'd0, 5'd7, 1, 64'h0000_0000_8000_0000);
    // sh at offset 6
    run_op(2'b01, 3'b001, 2'b01, 64'h2006, 64'hABCD, 5'd9, 0, 64'd0);
    // load+store both set behaves as load, with a 3-cycle ack delay
    run_op(2'b11, 3'b011, 2'b01, 64'h3000, 64'h55, 5'd3, 3, 64'hDEAD_BEEF_0123_4567);
`ifndef MEM_MISALIGN_TRAP_EN
    // Boundary-crossing half at offset 7 is truncated
    run_op(2'b10, 3'b001, 2'b01, 64'h4007, 64'd0, 5'd4, 0, 64'hFF00_0000_0000_0000);
    run_op(2'b01, 3'b010, 2'b01, 64'h4005, 64'h1122_3344, 5'd4, 0, 64'd0);
`endif

    // Stray ack in IDLE is ignored
    dmem_ack = 1'b1;
    @(negedge clk);
    check_eq("idle_ack_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack_req", 64'(dmem_req), 64'd0);
    check_eq("idle_ack_ctrl_wb", 64'(ctrl_wb), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of WAIT, then a late ack
    in_valid   = 1'b1;
    ctrl_mem   = 2'b10;
    funct3     = 3'b011;
    ctrl_wb_in = 2'b01;
    alu_result = 64'h5000;
    rd_in      = 5'd6;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("pre_rst_req", 64'(dmem_req), 64'd1);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check_eq("mid_rst_req", 64'(dmem_req), 64'd0);
    check_eq("mid_rst_stall", 64'(stall), 64'd0);
    check_eq("mid_rst_ctrl_wb", 64'(ctrl_wb), 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_ctrl_wb", 64'(ctrl_wb), 64'd0);
    check_eq("late_ack_mem_data", mem_data, 64'd0);
    @(posedge clk); #1;

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      logic [1:0]  cm  = 2'($urandom_range(0, 3));
      logic [2:0]  f3  = 3'($urandom_range(0, 6));
      logic [63:0] alu = {$urandom, $urandom};
      if (cm == 2'b01) f3[2] = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (cm != 2'b00) alu[2:0] = alu[2:0] & ~3'(size_of(f3) - 1);
`endif
      run_op(cm, f3, 2'($urandom_range(0, 3)), alu, {$urandom, $urandom},
             5'($urandom_range(0, 31)), $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
